// File: rtl/nivel_pkg.sv
// Shared types and pattern helpers for the tank level controller.
package nivel_pkg;

  typedef enum logic [1:0] {IDLE, FILL, FAULT} state_t;

  // A probe pattern is consistent only as a thermometer code (no wet probe above a dry one).
  function automatic logic thermo_ok(input logic [31:0] p);
    return (p & (p + 32'd1)) == 32'd0;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] p);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += {31'd0, p[i]};
    return c;
  endfunction

endpackage

// File: rtl/nivel_debounce.sv
// Per-probe 2-flop synchroniser followed by a stable-count debounce filter.
// Latency: a clean change reaches q DEB_CYC+2 edges after it is applied.
// Backpressure: none; free-running filter.
module nivel_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      q   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      // Any return to the accepted value restarts the stability count.
      if (s2 == q) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nivel_controle.sv
// Tank level controller: debounced probes, hysteresis inlet valve FSM, latched pattern fault (fill watchdog under NIVEL_TIMEOUT_EN).
// Latency: probe change to nivel/Ve/Al is DEB_CYC+3 edges; all outputs registered.
// Backpressure: none; clr is a single-cycle request sampled every edge.
module nivel_controle
  import nivel_pkg::*;
#(
  parameter int N_SENS   = 3,
  parameter int DEB_CYC  = 4,
  parameter int ERR_CYC  = 8,
  parameter int LOW_LVL  = 1,
  parameter int ALM_LVL  = 1,
  parameter int FILL_TMO = 1000,
  localparam int LW      = $clog2(N_SENS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SENS-1:0] sens,
  input  logic              clr,
  output logic              Ve,
  output logic              Al,
  output logic              ERRO,
  output logic [LW-1:0]     nivel
);

  localparam int EW = $clog2(ERR_CYC + 1);

  logic [N_SENS-1:0] filt;
  logic [LW-1:0]     lvl;
  logic              valid;
  logic              alm;
  logic [EW-1:0]     err_cnt;
  logic [EW-1:0]     err_nxt;
  logic              tmo;
  logic              go_fault;
  state_t            state;

  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    nivel_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sens[i]),
      .q     (filt[i])
    );
  end

  assign lvl   = LW'(popcount(32'(filt)));
  assign valid = thermo_ok(32'(filt));
  assign alm   = int'(lvl) < ALM_LVL;

  assign err_nxt = valid ? '0 :
                   (err_cnt == EW'(ERR_CYC)) ? err_cnt : err_cnt + EW'(1);

`ifdef NIVEL_TIMEOUT_EN
  localparam int TW = $clog2(FILL_TMO + 1);
  logic [TW-1:0] fill_cnt;

  // Counts edges spent in FILL; held at zero everywhere else so entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fill_cnt <= '0;
    else if (state != FILL)  fill_cnt <= '0;
    else                     fill_cnt <= fill_cnt + TW'(1);
  end

  assign tmo = (state == FILL) && (fill_cnt == TW'(FILL_TMO - 1));
`else
  // Watchdog absent: constant-false, FILL_TMO has no effect in this build.
  assign tmo = (FILL_TMO < 0);
`endif

  assign go_fault = (!valid && (err_nxt == EW'(ERR_CYC))) || tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      err_cnt <= '0;
      nivel   <= '0;
      Ve      <= 1'b0;
      Al      <= 1'b0;
      ERRO    <= 1'b0;
    end else begin
      err_cnt <= err_nxt;
      nivel   <= lvl;
      if (go_fault) begin
        state <= FAULT;
        Ve    <= 1'b0;
        Al    <= 1'b1;
        ERRO  <= 1'b1;
      end else begin
        if (state != FAULT) Al <= alm;
        unique case (state)
          IDLE: if (int'(lvl) <= LOW_LVL) begin
            state <= FILL;
            Ve    <= 1'b1;
          end
          FILL: if (int'(lvl) == N_SENS) begin
            state <= IDLE;
            Ve    <= 1'b0;
          end
          FAULT: if (clr && valid && (err_cnt == '0)) begin
            state <= IDLE;
            ERRO  <= 1'b0;
            Al    <= alm;
          end
          default: begin
            state <= IDLE;
            Ve    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nivel_controle.sv
// Randomised and directed bench for nivel_controle against a behavioural tank model.
module tb_nivel_controle;

  localparam int N    = 3;
  localparam int DEB  = 4;
  localparam int ERRC = 8;
  localparam int LOW  = 1;
  localparam int ALM  = 1;
  localparam int TMO  = 50;
  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_FAULT = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic [2:0] sens  = 3'b000;
  logic       Ve;
  logic       Al;
  logic       ERRO;
  logic [1:0] nivel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nivel_controle #(
    .N_SENS(N), .DEB_CYC(DEB), .ERR_CYC(ERRC),
    .LOW_LVL(LOW), .ALM_LVL(ALM), .FILL_TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sens(sens), .clr(clr),
    .Ve(Ve), .Al(Al), .ERRO(ERRO), .nivel(nivel)
  );

  // Behavioural model: probes seen two edges late, accepted after DEB disagreeing edges.
  logic [2:0] m_s1, m_s2, m_filt;
  int         m_run [3];
  int         m_err, m_mode, m_age, m_lvl;
  logic       m_ve, m_al, m_erro;

  function automatic int count1(input logic [2:0] p);
    int c = 0;
    for (int i = 0; i < 3; i++) if (p[i]) c++;
    return c;
  endfunction

  function automatic bit is_thermo(input logic [2:0] p);
    for (int k = 0; k <= N; k++) if (p == 3'((1 << k) - 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_filt = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_err = 0; m_mode = M_IDLE; m_age = 0; m_lvl = 0;
    m_ve = 1'b0; m_al = 1'b0; m_erro = 1'b0;
  endtask

  task automatic model_step();
    int  lvl, err_n, nm;
    bit  ok, fault;
    lvl   = count1(m_filt);
    ok    = is_thermo(m_filt);
    err_n = ok ? 0 : ((m_err + 1 > ERRC) ? ERRC : m_err + 1);
    fault = !ok && (err_n == ERRC);
`ifdef NIVEL_TIMEOUT_EN
    if (m_mode == M_FILL && m_age + 1 >= TMO) fault = 1'b1;
`endif
    nm = m_mode;
    if (fault) nm = M_FAULT;
    else if (m_mode == M_IDLE && lvl <= LOW) nm = M_FILL;
    else if (m_mode == M_FILL && lvl == N) nm = M_IDLE;
    else if (m_mode == M_FAULT && clr && ok && m_err == 0) nm = M_IDLE;
    m_age  = (nm == M_FILL && m_mode == M_FILL) ? m_age + 1 : 0;
    m_mode = nm;
    m_err  = err_n;
    m_lvl  = lvl;
    m_ve   = (nm == M_FILL);
    m_erro = (nm == M_FAULT);
    m_al   = (nm == M_FAULT) || (lvl < ALM);
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin
          m_filt[i] = m_s2[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = sens;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (Ve !== m_ve || Al !== m_al || ERRO !== m_erro || nivel !== 2'(m_lvl)) begin
        fails++;
        $display("FAIL model_cmp t=%0t got Ve=%b Al=%b ERRO=%b nivel=%0d expected Ve=%b Al=%b ERRO=%b nivel=%0d",
                 $time, Ve, Al, ERRO, nivel, m_ve, m_al, m_erro, m_lvl);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_Ve"},    32'(Ve),    0);
    check({tag, "_Al"},    32'(Al),    0);
    check({tag, "_ERRO"},  32'(ERRO),  0);
    check({tag, "_nivel"}, 32'(nivel), 0);
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_fill_Ve", 32'(Ve), 1);
    check("rst_fill_Al", 32'(Al), 1);
    check("rst_ERRO",    32'(ERRO), 0);
    check("rst_nivel",   32'(nivel), 0);

    // Fill upward one probe at a time.
    sens = 3'b001; tick(6);
    check("n1_early", 32'(nivel), 0);
    tick(1);
    check("n1_nivel", 32'(nivel), 1);
    check("n1_Al",    32'(Al), 0);
    check("n1_Ve",    32'(Ve), 1);
    tick(13);
    sens = 3'b011; tick(7);
    check("n2_nivel", 32'(nivel), 2);
    check("n2_Ve",    32'(Ve), 1);
    tick(13);
    sens = 3'b111; tick(6);
    check("full_Ve_early", 32'(Ve), 1);
    tick(1);
    check("full_nivel", 32'(nivel), 3);
    check("full_Ve",    32'(Ve), 0);
    tick(13);

    // Short glitch must be filtered out.
    sens = 3'b011; tick(3);
    sens = 3'b111; tick(10);
    check("glitch_nivel", 32'(nivel), 3);

    // Drain: no refill until level drops to LOW.
    sens = 3'b011; tick(20);
    check("drain2_Ve", 32'(Ve), 0);
    check("drain2_nivel", 32'(nivel), 2);
    sens = 3'b001; tick(6);
    check("drain1_Ve_early", 32'(Ve), 0);
    tick(1);
    check("drain1_Ve", 32'(Ve), 1);

    // Inconsistent pattern -> fault at edge DEB+2+ERRC = 14.
    sens = 3'b101; tick(13);
    check("flt_early", 32'(ERRO), 0);
    tick(1);
    check("flt_ERRO", 32'(ERRO), 1);
    check("flt_Al",   32'(Al), 1);
    check("flt_Ve",   32'(Ve), 0);
    clr = 1'b1; tick(3); clr = 1'b0;
    check("clr_invalid_ERRO", 32'(ERRO), 1);
    sens = 3'b111; tick(10);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_ok_ERRO", 32'(ERRO), 0);
    check("clr_ok_Ve",   32'(Ve), 0);
    tick(2);

    // Async reset mid-fault and mid-fill.
    sens = 3'b101; tick(16);
    check("pre_rst_ERRO", 32'(ERRO), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_fault");
    @(negedge clk);
    sens = 3'b000; rst_n = 1'b1;
    tick(3);
    check("refill_Ve", 32'(Ve), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_fill");
    @(negedge clk);
    rst_n = 1'b1;

    // Dry source held: watchdog fault or indefinite fill.
    tick(1);
    check("dry_Ve", 32'(Ve), 1);
`ifdef NIVEL_TIMEOUT_EN
    tick(TMO - 1);
    check("tmo_early", 32'(ERRO), 0);
    tick(1);
    check("tmo_ERRO", 32'(ERRO), 1);
`else
    tick(200);
    check("dry_Ve_200", 32'(Ve), 1);
    check("dry_ERRO_200", 32'(ERRO), 0);
`endif

    // Randomised phase: mostly consistent levels, some invalid patterns and glitches.
    for (int it = 0; it < 300; it++) begin
      int hold;
      if ($urandom_range(0, 9) < 7) sens = 3'((1 << $urandom_range(0, 3)) - 1);
      else                          sens = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        clr = ($urandom_range(0, 5) == 0);
        tick(1);
      end
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_zero("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    clr = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
